// File: rtl/lcd_controller.sv
// lcd_controller: parallel RGB565 LCD timing generator with a DMA-fed pixel FIFO
// and a backlight PWM. Everything runs on CLK. The pixel clock is CLK/4.
//
// Ports:
//   CLK, RESET_N             sole clock (rising edge) and async active-low reset
//   CLK_PXCLK                pixel clock to the panel, CLK/4, 50% duty
//   HSYNC, VSYNC             active-low sync pulses
//   DE                       data enable, high on visible pixels
//   PIXEL_DATA[15:0]         RGB565 pixel, 0 outside the visible area or on underflow
//   ROW_INDEX[8:0]           current row counter
//   BUFFER_START_ADDRESS     frame buffer base (32-bit word address)
//   DMA_RD_ADDR, DMA_START   burst request (address held for the whole burst)
//   DMA_READY                DMA idle, may accept a request
//   DMA_RD_DATA(_VALID)      burst data words
//   BACKLIGHT_BRIGHTNESS     PWM duty, 0 = dark, 255 = brightest
//   BACKLIGHT_PWM            backlight PWM output
module lcd_controller #(
    parameter int unsigned HPIXELS     = 480,
    parameter int unsigned VPIXELS     = 272,
    parameter int unsigned HFP         = 2,
    parameter int unsigned HSW         = 41,
    parameter int unsigned HBP         = 2,
    parameter int unsigned VFP         = 2,
    parameter int unsigned VSW         = 10,
    parameter int unsigned VBP         = 2,
    parameter int unsigned BURST_WORDS = 8,
    parameter int unsigned FIFO_DEPTH  = 64
) (
    input  logic        CLK,
    input  logic        RESET_N,
    output logic        CLK_PXCLK,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        DE,
    output logic [15:0] PIXEL_DATA,
    output logic [8:0]  ROW_INDEX,
    input  logic [29:0] BUFFER_START_ADDRESS,
    output logic [29:0] DMA_RD_ADDR,
    output logic        DMA_START,
    input  logic        DMA_READY,
    input  logic [31:0] DMA_RD_DATA,
    input  logic        DMA_RD_DATA_VALID,
    input  logic [7:0]  BACKLIGHT_BRIGHTNESS,
    output logic        BACKLIGHT_PWM
);

    localparam int unsigned HTOTAL   = HPIXELS + HFP + HSW + HBP;
    localparam int unsigned VTOTAL   = VPIXELS + VFP + VSW + VBP;
    localparam int unsigned HS_START = HPIXELS + HFP;
    localparam int unsigned HS_END   = HS_START + HSW;
    localparam int unsigned VS_START = VPIXELS + VFP;
    localparam int unsigned VS_END   = VS_START + VSW;
    localparam int unsigned NBURSTS  = (HPIXELS * VPIXELS) / (2 * BURST_WORDS);
    localparam int unsigned XW       = $clog2(HTOTAL);
    localparam int unsigned YW       = $clog2(VTOTAL);
    localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW       = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned RW       = $clog2(NBURSTS + 1);
    localparam int unsigned BW       = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    // ------------------------------------------------------------------
    // Pixel clock phase; the tick is the edge entering phase 2
    // ------------------------------------------------------------------
    logic [1:0] phase;
    logic       tick_c;

    assign tick_c = (phase == 2'd1);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            phase     <= 2'd0;
            CLK_PXCLK <= 1'b0;
        end else begin
            phase     <= phase + 2'd1;
            // high whenever the phase being entered is 0 or 1
            CLK_PXCLK <= (phase == 2'd3) || (phase == 2'd0);
        end
    end

    // ------------------------------------------------------------------
    // Raster position decode
    // ------------------------------------------------------------------
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [31:0]   xw_c;
    logic [31:0]   yw_c;
    logic          x_last_c;
    logic          y_last_c;
    logic          visible_c;
    logic          frame_end_c;

    assign xw_c        = 32'(x);
    assign yw_c        = 32'(y);
    assign x_last_c    = (xw_c == HTOTAL - 1);
    assign y_last_c    = (yw_c == VTOTAL - 1);
    assign visible_c   = (xw_c < HPIXELS) && (yw_c < VPIXELS);
    // y is about to become VPIXELS: the visible frame is done
    assign frame_end_c = tick_c && x_last_c && (yw_c == VPIXELS - 1);

    // ------------------------------------------------------------------
    // Pixel FIFO (32-bit words, two pixels each)
    // ------------------------------------------------------------------
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          half_hi;
    logic          stale;
    logic          fifo_full_c;
    logic          push_c;
    logic          show_c;
    logic          pop_c;
    logic [31:0]   head_c;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + AW'(1);
    endfunction

    assign fifo_full_c = (32'(count) == FIFO_DEPTH);
    // Words of a burst issued before the frame flush never enter the FIFO
    assign push_c      = DMA_RD_DATA_VALID && !stale && !frame_end_c && !fifo_full_c;
    assign show_c      = tick_c && visible_c && (count != '0);
    assign pop_c       = show_c && half_hi;
    assign head_c      = mem[rd_ptr];

    // Storage array
    always_ff @(posedge CLK) begin
        if (push_c) begin
            mem[wr_ptr] <= DMA_RD_DATA;
        end
    end

    // FIFO pointers, occupancy and half-word select
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            half_hi <= 1'b0;
        end else if (frame_end_c) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            half_hi <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_c) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (show_c) begin
                half_hi <= !half_hi;
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Panel outputs and raster counters, all advanced on the pixel tick
    // ------------------------------------------------------------------
    logic [7:0] pwm_cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            HSYNC         <= 1'b1;
            VSYNC         <= 1'b1;
            DE            <= 1'b0;
            PIXEL_DATA    <= 16'h0000;
            ROW_INDEX     <= 9'd0;
            BACKLIGHT_PWM <= 1'b0;
            pwm_cnt       <= 8'd0;
            x             <= '0;
            y             <= '0;
        end else if (tick_c) begin
            HSYNC         <= !((xw_c >= HS_START) && (xw_c < HS_END));
            VSYNC         <= !((yw_c >= VS_START) && (yw_c < VS_END));
            DE            <= visible_c;
            ROW_INDEX     <= 9'(y);
            PIXEL_DATA    <= show_c ? (half_hi ? head_c[31:16] : head_c[15:0]) : 16'h0000;
            BACKLIGHT_PWM <= (pwm_cnt < BACKLIGHT_BRIGHTNESS);
            pwm_cnt       <= pwm_cnt + 8'd1;
            if (x_last_c) begin
                x <= '0;
                y <= y_last_c ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // DMA fetch FSM: state register
    // ------------------------------------------------------------------
    logic [1:0]    state;
    logic [1:0]    state_n;
    logic [29:0]   fetch_addr;
    logic [29:0]   fetch_addr_n;
    logic [29:0]   dma_addr_n;
    logic [RW-1:0] bursts_left;
    logic [RW-1:0] bursts_left_n;
    logic [BW-1:0] rx_cnt;
    logic [BW-1:0] rx_cnt_n;
    logic          stale_n;
    logic          dma_start_n;
    logic          can_issue_c;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= ST_INIT;
            fetch_addr  <= '0;
            DMA_RD_ADDR <= '0;
            bursts_left <= '0;
            rx_cnt      <= '0;
            stale       <= 1'b0;
            DMA_START   <= 1'b0;
        end else begin
            state       <= state_n;
            fetch_addr  <= fetch_addr_n;
            DMA_RD_ADDR <= dma_addr_n;
            bursts_left <= bursts_left_n;
            rx_cnt      <= rx_cnt_n;
            stale       <= stale_n;
            DMA_START   <= dma_start_n;
        end
    end

    // Requests are only made from idle, so no words are in flight at that
    // point and the FIFO free space alone decides whether a burst fits.
    assign can_issue_c = (bursts_left != '0) && DMA_READY && !frame_end_c &&
                         (32'(count) + BURST_WORDS <= FIFO_DEPTH);

    // DMA fetch FSM: next state and registered outputs
    always_comb begin
        state_n       = state;
        fetch_addr_n  = fetch_addr;
        dma_addr_n    = DMA_RD_ADDR;
        bursts_left_n = bursts_left;
        rx_cnt_n      = rx_cnt;
        stale_n       = stale;
        dma_start_n   = 1'b0;

        case (state)
            ST_INIT: begin
                // first frame is prefetched straight after reset release
                fetch_addr_n  = BUFFER_START_ADDRESS;
                bursts_left_n = RW'(NBURSTS);
                state_n       = ST_IDLE;
            end
            ST_IDLE: begin
                if (can_issue_c) begin
                    dma_start_n   = 1'b1;
                    dma_addr_n    = fetch_addr;
                    fetch_addr_n  = fetch_addr + 30'(BURST_WORDS);
                    bursts_left_n = bursts_left - RW'(1);
                    rx_cnt_n      = '0;
                    state_n       = ST_BURST;
                end
            end
            ST_BURST: begin
                if (DMA_RD_DATA_VALID) begin
                    if (32'(rx_cnt) == BURST_WORDS - 1) begin
                        rx_cnt_n = '0;
                        stale_n  = 1'b0;
                        state_n  = ST_IDLE;
                    end else begin
                        rx_cnt_n = rx_cnt + BW'(1);
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Frame flush: restart fetching and orphan any burst still in flight
        if (frame_end_c) begin
            fetch_addr_n  = BUFFER_START_ADDRESS;
            bursts_left_n = RW'(NBURSTS);
            if (state_n == ST_BURST) begin
                stale_n = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_controller.sv
// Bench for lcd_controller with a shrunken panel geometry: random DMA
// latency/gaps and pixel data, a queue-based pixel reference and raster
// position derived from the tick count.
module tb_lcd_controller;

    localparam int unsigned HP  = 16;
    localparam int unsigned VP  = 6;
    localparam int unsigned HFP = 2;
    localparam int unsigned HSW = 3;
    localparam int unsigned HBP = 2;
    localparam int unsigned VFP = 1;
    localparam int unsigned VSW = 2;
    localparam int unsigned VBP = 1;
    localparam int unsigned BW  = 4;
    localparam int unsigned FD  = 16;
    localparam int unsigned HT  = HP + HFP + HSW + HBP;
    localparam int unsigned VT  = VP + VFP + VSW + VBP;
    localparam int unsigned NB  = (HP * VP) / (2 * BW);

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic        CLK_PXCLK;
    logic        HSYNC;
    logic        VSYNC;
    logic        DE;
    logic [15:0] PIXEL_DATA;
    logic [8:0]  ROW_INDEX;
    logic [29:0] BUFFER_START_ADDRESS = '0;
    logic [29:0] DMA_RD_ADDR;
    logic        DMA_START;
    logic        DMA_READY = 1'b0;
    logic [31:0] DMA_RD_DATA = '0;
    logic        DMA_RD_DATA_VALID = 1'b0;
    logic [7:0]  BACKLIGHT_BRIGHTNESS = 8'd100;
    logic        BACKLIGHT_PWM;

    int n_vec = 0;
    int n_err = 0;

    // reference state
    int          k_edge = 0;
    int          n_tick = 0;
    int          epoch = 0;
    int          bursts_left = 0;
    int          frame_bursts = 0;
    int          pwm_hi = 0;
    bit          have_flush = 1'b0;
    bit          frame_clean = 1'b0;
    logic [29:0] addr_exp = '0;
    logic [15:0] halfq[$];

    // DMA responder state
    bit          hold_ready = 1'b0;
    bit          busy = 1'b0;
    int          words_left = 0;
    int          delay = 0;
    int          b_epoch = 0;
    int          w_epoch = 0;
    logic [29:0] burst_addr = '0;

    lcd_controller #(
        .HPIXELS(HP), .VPIXELS(VP), .HFP(HFP), .HSW(HSW), .HBP(HBP),
        .VFP(VFP), .VSW(VSW), .VBP(VBP), .BURST_WORDS(BW), .FIFO_DEPTH(FD)
    ) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .CLK_PXCLK(CLK_PXCLK),
        .HSYNC(HSYNC),
        .VSYNC(VSYNC),
        .DE(DE),
        .PIXEL_DATA(PIXEL_DATA),
        .ROW_INDEX(ROW_INDEX),
        .BUFFER_START_ADDRESS(BUFFER_START_ADDRESS),
        .DMA_RD_ADDR(DMA_RD_ADDR),
        .DMA_START(DMA_START),
        .DMA_READY(DMA_READY),
        .DMA_RD_DATA(DMA_RD_DATA),
        .DMA_RD_DATA_VALID(DMA_RD_DATA_VALID),
        .BACKLIGHT_BRIGHTNESS(BACKLIGHT_BRIGHTNESS),
        .BACKLIGHT_PWM(BACKLIGHT_PWM)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_pxclk"}, 32'(CLK_PXCLK), 0);
        check_eq({tag, "_hsync"}, 32'(HSYNC), 1);
        check_eq({tag, "_vsync"}, 32'(VSYNC), 1);
        check_eq({tag, "_de"}, 32'(DE), 0);
        check_eq({tag, "_pixel"}, 32'(PIXEL_DATA), 0);
        check_eq({tag, "_row"}, 32'(ROW_INDEX), 0);
        check_eq({tag, "_start"}, 32'(DMA_START), 0);
        check_eq({tag, "_addr"}, 32'(DMA_RD_ADDR), 0);
        check_eq({tag, "_pwm"}, 32'(BACKLIGHT_PWM), 0);
    endtask

    // Evaluate what the DUT did at the posedge just passed (inputs still hold
    // the values it sampled there).
    task automatic process();
        int          x;
        int          y;
        bit          vis;
        logic [15:0] pe;
        k_edge++;
        check_eq("pxclk", 32'(CLK_PXCLK), 32'((k_edge % 4) < 2));
        if (busy) begin
            check_eq("addr_hold", 32'(DMA_RD_ADDR), 32'(burst_addr));
        end
        if ((k_edge % 4) == 2) begin
            x   = n_tick % HT;
            y   = (n_tick / HT) % VT;
            vis = (x < HP) && (y < VP);
            pe  = 16'h0000;
            if (hold_ready) frame_clean = 1'b0;
            if (vis) begin
                if (halfq.size() > 0) pe = halfq.pop_front();
                else frame_clean = 1'b0;
            end
            check_eq("de", 32'(DE), 32'(vis));
            check_eq("hsync", 32'(HSYNC), 32'(!(x >= HP + HFP && x < HP + HFP + HSW)));
            check_eq("vsync", 32'(VSYNC), 32'(!(y >= VP + VFP && y < VP + VFP + VSW)));
            check_eq("row", 32'(ROW_INDEX), 32'(y));
            check_eq("pixel", 32'(PIXEL_DATA), 32'(pe));
            check_eq("pwm", 32'(BACKLIGHT_PWM), 32'((n_tick % 256) < int'(BACKLIGHT_BRIGHTNESS)));
            pwm_hi += int'(BACKLIGHT_PWM);
            n_tick++;
            if (x == HT - 1 && y == VP - 1) begin
                halfq.delete();
                epoch++;
                if (have_flush && frame_clean) begin
                    check_eq("bursts_per_frame", 32'(frame_bursts), 32'(NB));
                end
                have_flush   = 1'b1;
                frame_clean  = 1'b1;
                frame_bursts = 0;
                addr_exp     = BUFFER_START_ADDRESS;
                bursts_left  = NB;
            end
        end
        if (DMA_RD_DATA_VALID && w_epoch == epoch) begin
            halfq.push_back(DMA_RD_DATA[15:0]);
            halfq.push_back(DMA_RD_DATA[31:16]);
        end
        if (DMA_START) begin
            check_eq("start_handshake", 32'({busy, DMA_READY}), 32'(2'b01));
            check_eq("start_addr", 32'(DMA_RD_ADDR), 32'(addr_exp));
            check_eq("start_left", 32'(bursts_left > 0), 1);
            burst_addr  = addr_exp;
            addr_exp    = addr_exp + 30'(BW);
            bursts_left--;
            frame_bursts++;
            busy       = 1'b1;
            words_left = BW;
            delay      = $urandom_range(0, 3);
            b_epoch    = epoch;
        end
    endtask

    // DMA responder: inputs for the next posedge
    task automatic drive();
        DMA_RD_DATA_VALID = 1'b0;
        DMA_RD_DATA       = $urandom;
        if (busy) begin
            if (delay > 0) begin
                delay--;
            end else if ($urandom_range(0, 3) != 0) begin
                DMA_RD_DATA_VALID = 1'b1;
                DMA_RD_DATA       = {16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535))};
                w_epoch           = b_epoch;
                words_left--;
                if (words_left == 0) busy = 1'b0;
            end
        end
        DMA_READY = !busy && !hold_ready;
    endtask

    task automatic cycle();
        @(negedge CLK);
        if (RESET_N) begin
            process();
            drive();
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Called at a negedge: releases reset and restarts the reference.
    task automatic release_reset(input logic [29:0] base);
        BUFFER_START_ADDRESS = base;
        DMA_RD_DATA_VALID    = 1'b0;
        busy         = 1'b0;
        k_edge       = 0;
        n_tick       = 0;
        halfq.delete();
        epoch++;
        addr_exp     = base;
        bursts_left  = NB;
        frame_bursts = 0;
        have_flush   = 1'b0;
        frame_clean  = 1'b0;
        DMA_READY    = !hold_ready;
        RESET_N      = 1'b1;
    endtask

    initial begin
        int     levels[4];
        int     waited;
        levels = '{0, 8, 128, 255};

        #1 RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        #1 check_reset_values("rst");
        @(negedge CLK);
        release_reset(30'h1000_0000);

        // responsive DMA, random brightness
        for (int i = 0; i < 7; i++) begin
            BACKLIGHT_BRIGHTNESS = 8'($urandom_range(0, 255));
            run(400);
        end

        // PWM duty over exactly 256 pixel ticks per level
        foreach (levels[i]) begin
            BACKLIGHT_BRIGHTNESS = 8'(levels[i]);
            pwm_hi = 0;
            run(1024);
            check_eq("pwm_duty", 32'(pwm_hi), 32'(levels[i]));
        end

        // DMA never ready: no requests, starved rows show 0
        hold_ready = 1'b1;
        run(1300);
        hold_ready = 1'b0;
        run(1200);

        // asynchronous reset in the middle of a burst
        waited = 0;
        while (!(busy && words_left < int'(BW)) && waited < 400) begin
            cycle();
            waited++;
        end
        check_eq("midburst_found", 32'(busy && words_left < int'(BW)), 1);
        #2 RESET_N = 1'b0;
        #1 check_reset_values("async_rst");
        for (int i = 0; i < 3; i++) begin
            DMA_RD_DATA_VALID = 1'b1;
            DMA_RD_DATA       = $urandom;
            @(negedge CLK);
        end
        check_reset_values("rst_hold");
        release_reset(30'h3FFF_FFE8);
        run(2800);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_controller.md
LCD_CONTROLLER -- requirements
Module: lcd_controller

Interface
REQ-001 SHALL have parameters: HPIXELS=480 visible px/row; VPIXELS=272 visible rows; HFP=2, HSW=41, HBP=2 px clocks; VFP=2, VSW=10, VBP=2 rows; BURST_WORDS=8 words per DMA burst; FIFO_DEPTH=64 32-bit words.
REQ-002 SHALL have ports (name, direction, width, meaning):
- CLK  in  1  sole clock, rising edge; DMA, FIFO and timing all run on it
- RESET_N  in  1  asynchronous, active-low reset
- CLK_PXCLK  out  1  pixel clock = CLK/4, 50% duty
- HSYNC  out  1  horizontal sync, active low
- VSYNC  out  1  vertical sync, active low
- DE  out  1  data enable, high for visible pixels
- PIXEL_DATA  out  16  RGB565 pixel
- ROW_INDEX  out  9  current row counter, 0..VPIXELS-1 visible
- BUFFER_START_ADDRESS  in  30  frame buffer base, 32-bit word address
- DMA_RD_ADDR  out  30  burst start address
- DMA_START  out  1  one-cycle burst request
- DMA_READY  in  1  DMA idle, may accept request
- DMA_RD_DATA  in  32  burst data word
- DMA_RD_DATA_VALID  in  1  DMA_RD_DATA valid this cycle
- BACKLIGHT_BRIGHTNESS  in  8  0=dark, 255=brightest
- BACKLIGHT_PWM  out  1  backlight PWM

Function
REQ-003 SHALL use a 2-bit phase counter: CLK_PXCLK=1 in phases 0,1 and 0 in phases 2,3; the pixel tick SHALL be the CLK edge entering phase 2 (CLK_PXCLK falling).
REQ-004 SHALL update HSYNC, VSYNC, DE, PIXEL_DATA, ROW_INDEX and BACKLIGHT_PWM only on pixel ticks, so the panel samples them stably on the CLK_PXCLK rising edge.
REQ-005 SHALL keep x counter 0..HTOTAL-1 (HTOTAL=HPIXELS+HFP+HSW+HBP=525) and y counter 0..VTOTAL-1 (VTOTAL=286); y SHALL increment when x wraps and SHALL wrap to 0 after VTOTAL-1.
REQ-006 SHALL drive HSYNC=0 for x in [HPIXELS+HFP, HPIXELS+HFP+HSW), else 1; VSYNC=0 for y in [VPIXELS+VFP, VPIXELS+VFP+VSW), else 1.
REQ-007 SHALL drive DE=1 iff x<HPIXELS and y<VPIXELS; ROW_INDEX SHALL equal y.
REQ-008 SHALL contain a synchronous FIFO of FIFO_DEPTH 32-bit words written by every cycle with DMA_RD_DATA_VALID=1.
REQ-009 SHALL emit, per DE=1 tick, DMA_RD_DATA[15:0] of the head word first, then [31:16], popping the word after its high half.
REQ-010 SHALL output PIXEL_DATA=0 while DE=0, and PIXEL_DATA=0 without popping if the FIFO is empty at a DE=1 tick (underflow).
REQ-011 SHALL, on the tick where y becomes VPIXELS (end of visible frame), flush the FIFO, reset the half-select, load the fetch address from BUFFER_START_ADDRESS and set the remaining-burst count to HPIXELS*VPIXELS/(2*BURST_WORDS)=8160.
REQ-012 SHALL assert DMA_START for exactly one CLK when: remaining bursts >0, DMA_READY=1, no own burst outstanding, and FIFO free space >= BURST_WORDS counting words in flight.
REQ-013 SHALL hold DMA_RD_ADDR at the current fetch address during the request and burst; after each request it SHALL add BURST_WORDS to the fetch address and decrement the remaining count.
REQ-014 SHALL treat a burst as outstanding from DMA_START until BURST_WORDS valid words have been received.
REQ-015 SHALL discard valid words arriving from a burst issued before the frame flush, so they never reach the FIFO.
REQ-016 SHALL keep an 8-bit PWM counter incremented per pixel tick, wrapping 255->0; BACKLIGHT_PWM = (counter < BACKLIGHT_BRIGHTNESS): 0 always off, 255 on 255/256 of the time.
REQ-017 SHALL use modulo-2^30 address arithmetic.

Reset
REQ-018 SHALL, while RESET_N=0, force CLK_PXCLK=0, phase=0, HSYNC=1, VSYNC=1, DE=0, PIXEL_DATA=0, ROW_INDEX=0, x=y=0, DMA_START=0, DMA_RD_ADDR=0, BACKLIGHT_PWM=0, PWM counter 0, FIFO empty, no burst outstanding.
REQ-019 SHALL set remaining bursts to 8160 from BUFFER_START_ADDRESS on release, so the first frame is prefetched at once; a reset mid-burst SHALL abandon the burst.

Verification
REQ-020 Reset release -> CLK_PXCLK toggles every 2 CLK; row period 2100 CLK; frame 286 rows; HSYNC low 41 px clocks starting at x=482.
REQ-021 BUFFER_START_ADDRESS=0x10000000, responsive DMA model -> first DMA_RD_ADDR=0x10000000, then +8 per burst; 8160 bursts per frame; never two outstanding.
REQ-022 Data word {hi,lo} -> PIXEL_DATA shows lo then hi on consecutive DE ticks; 480 DE ticks per row, 272 rows.
REQ-023 DMA_READY held 0 -> no DMA_START, DE rows output PIXEL_DATA=0, timing unaffected.
REQ-024 BACKLIGHT_BRIGHTNESS 0/8/128/255 -> PWM high 0/8/128/255 of every 256 pixel ticks.
REQ-025 RESET_N pulled low mid-burst -> all outputs at reset values asynchronously; stale burst data is not shown after restart.
